// File: rtl/stage_if.sv
// ---------------------------------------------------------------------------
// stage_if -- instruction fetch stage
//
// Issues one instruction memory request at a time from the fetch PC (pc_r),
// delivers fetched words to decode at up to one per cycle, and redirects on
// taken branches/jumps from execute.
//
// Handshakes:
//   imem_req/imem_ack : imem_req stays high with a stable imem_addr until a
//                       single-cycle imem_ack arrives; imem_rdata is valid in
//                       the ack cycle. A request is never withdrawn.
//   if_valid/stall    : decode takes the instruction on a rising edge where
//                       if_valid=1 and stall=0; while stall=1 the outputs
//                       hold their value.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   br_ctrl, br_pc     redirect strobe and target (low two bits ignored)
//   stall              decode cannot accept an instruction this cycle
//   imem_req/addr      memory request and address (addr is pc_r)
//   imem_ack/rdata     memory response
//   if_pc/inst/valid   delivered instruction to decode
//   dbg_state          current FSM state (0=FETCH, 1=HOLD, 2=DRAIN)
// ---------------------------------------------------------------------------
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ctrl,
  input  logic [31:0] br_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [1:0]  dbg_state
);

  // FETCH : request outstanding at pc_r
  // HOLD  : word fetched while decode stalled, parked in the skid buffer
  // DRAIN : redirect arrived before the outstanding ack; wait it out
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] redir_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;

  assign pc_plus4  = pc_r + 32'd4;              // wraps naturally at 2^32
  assign br_tgt    = {br_pc[31:2], 2'b00};      // targets are word aligned

  // HOLD has nowhere to put another word, so no request is issued there.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc_r;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_r      <= RESET_PC;
      redir_pc  <= 32'h0;
      skid_pc   <= 32'h0;
      skid_inst <= 32'h0;
      if_valid  <= 1'b0;
      if_inst   <= NOP;
      if_pc     <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (br_ctrl) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              // Response for the old path is dropped; fetch the target now.
              pc_r <= br_tgt;
            end else begin
              // Request still in flight at the old address: remember the
              // target and let the stale response come back first.
              redir_pc <= br_tgt;
              state    <= DRAIN;
            end
          end else if (imem_ack) begin
            if (stall) begin
              skid_inst <= imem_rdata;
              skid_pc   <= pc_r;
              state     <= HOLD;
            end else begin
              if_inst  <= imem_rdata;
              if_pc    <= pc_r;
              if_valid <= 1'b1;
              pc_r     <= pc_plus4;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (br_ctrl) begin
            if_valid <= 1'b0;
            pc_r     <= br_tgt;
            state    <= FETCH;
          end else if (!stall) begin
            // pc_r still equals skid_pc here, so pc_plus4 is the next word.
            if_inst  <= skid_inst;
            if_pc    <= skid_pc;
            if_valid <= 1'b1;
            pc_r     <= pc_plus4;
            state    <= FETCH;
          end
        end

        DRAIN: begin
          if_valid <= 1'b0;
          if (br_ctrl) begin
            redir_pc <= br_tgt;
          end
          if (imem_ack) begin
            pc_r  <= br_ctrl ? br_tgt : redir_pc;
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// ---------------------------------------------------------------------------
// tb_stage_if -- bench for stage_if
// Main DUT uses RESET_PC=0 with a bench memory model (configurable latency
// and ack budget). A second DUT with RESET_PC=FFFF_FFFC runs against an
// always-acking memory to exercise PC wrap.
// ---------------------------------------------------------------------------
module tb_stage_if;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        = 1'b1;
  logic        br_ctrl    = 1'b0;
  logic [31:0] br_pc      = 32'h0;
  logic        stall      = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack   = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [1:0]  dbg_state;

  logic        br_ctrl2    = 1'b0;
  logic [31:0] br_pc2      = 32'h0;
  logic        stall2      = 1'b0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2   = 1'b0;
  logic [31:0] imem_rdata2 = 32'h0;
  logic [31:0] if_pc2;
  logic [31:0] if_inst2;
  logic        if_valid2;
  logic [1:0]  dbg_state2;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int   ack_budget = 0;
  int   ack_delay  = 0;
  int   wait_cnt   = 0;
  logic ack_force  = 1'b0;

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .br_pc(br_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .if_valid(if_valid), .dbg_state(dbg_state)
  );

  stage_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .br_ctrl(br_ctrl2), .br_pc(br_pc2), .stall(stall2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_rdata(imem_rdata2), .if_pc(if_pc2), .if_inst(if_inst2),
    .if_valid(if_valid2), .dbg_state(dbg_state2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  // ---------------- memory models (decide ack for the next rising edge) ----
  always @(negedge clk) begin
    if (ack_force) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req && ack_budget > 0) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
        ack_budget = ack_budget - 1;
      end else begin
        imem_ack = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    imem_ack2   = imem_req2;
    imem_rdata2 = mem_word(imem_addr2);
  end

  // ---------------- scoreboard: every accepted instruction ----------------
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL deliver_unexpected: got pc=%h inst=%h, want none", if_pc, if_inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (if_pc !== e || if_inst !== mem_word(e)) begin
          failures = failures + 1;
          $display("FAIL deliver: got pc=%h inst=%h, want pc=%h inst=%h",
                   if_pc, if_inst, e, mem_word(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    ack_budget = 0;
    br_ctrl = 1'b0;
    stall = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s: %0d expected deliveries missing, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks = checks + 1;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks = checks + 1;
    if (if_inst !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst: got %h want 00000013", if_inst); end
    checks = checks + 1;
    if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    checks = checks + 1;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    @(posedge clk);
    #1 rst = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    checks = checks + 1;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_ack_ignored: got valid=%b want 0", if_valid); end
  endtask

  task automatic test_sequential();
    ack_delay = 0;
    do_reset();
    ack_budget = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4)) begin
        failures++; $display("FAIL seq_cycle%0d: got valid=%b pc=%h want valid=1 pc=%h", i, if_valid, if_pc, 32'(i * 4));
      end
    end
    repeat (3) @(negedge clk);
    check_drained("seq_drain");
    checks = checks + 1;
    if (if_valid !== 1'b0 || if_pc !== 32'hC) begin
      failures++; $display("FAIL seq_bubble: got valid=%b pc=%h want valid=0 pc=0000000c", if_valid, if_pc);
    end
  endtask

  task automatic test_stall();
    ack_delay = 0;
    do_reset();
    ack_budget = 6;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    repeat (4) @(posedge clk);
    #1 stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin
      failures++; $display("FAIL stall_hold: got req=%b state=%0d want req=0 state=1", imem_req, dbg_state);
    end
    checks = checks + 1;
    if (if_pc !== 32'hC || if_valid !== 1'b1) begin
      failures++; $display("FAIL stall_frozen: got pc=%h valid=%b want pc=0000000c valid=1", if_pc, if_valid);
    end
    @(negedge clk);
    checks = checks + 1;
    if (if_pc !== 32'hC || imem_req !== 1'b0) begin
      failures++; $display("FAIL stall_frozen2: got pc=%h req=%b want pc=0000000c req=0", if_pc, imem_req);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    repeat (5) @(negedge clk);
    check_drained("stall_drain");
  endtask

  task automatic test_redirect();
    ack_delay = 2;
    do_reset();
    ack_budget = 3;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h200);
    repeat (3) @(posedge clk);
    #1 br_ctrl = 1'b1;
    br_pc = 32'h203;
    @(posedge clk);
    #1 br_ctrl = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (if_valid !== 1'b0 || dbg_state !== ST_DRAIN || imem_addr !== 32'h4) begin
      failures++; $display("FAIL redir_drain: got valid=%b state=%0d addr=%h want valid=0 state=2 addr=00000004",
                           if_valid, dbg_state, imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (imem_addr !== 32'h200 || dbg_state !== ST_FETCH || if_valid !== 1'b0) begin
      failures++; $display("FAIL redir_target: got addr=%h state=%0d valid=%b want addr=00000200 state=0 valid=0",
                           imem_addr, dbg_state, if_valid);
    end
    repeat (6) @(negedge clk);
    check_drained("redir_deliver");
    ack_delay = 0;
  endtask

  task automatic test_br_stall();
    logic [31:0] tgt;
    ack_delay = 0;
    do_reset();
    ack_budget = 5;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    tgt = 32'h100 | 32'($urandom_range(0, 3));
    repeat (2) @(posedge clk);
    #1 br_ctrl = 1'b1;
    stall = 1'b1;
    br_pc = tgt;
    @(posedge clk);
    #1 br_ctrl = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (if_valid !== 1'b0 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL br_stall: got valid=%b addr=%h want valid=0 addr=00000100 (br_pc=%h)",
                           if_valid, imem_addr, tgt);
    end
    repeat (5) @(negedge clk);
    check_drained("br_stall_resume");
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    do_reset();
    ack_budget = 12;
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1 stall = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    repeat (16) @(negedge clk);
    check_drained("b2b_random_stall");
  endtask

  task automatic test_rst_drain();
    ack_delay = 0;
    do_reset();
    br_ctrl = 1'b1;
    br_pc = 32'h300;
    @(posedge clk);
    #1 br_ctrl = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (dbg_state !== ST_DRAIN) begin failures++; $display("FAIL rst_drain_enter: got state=%0d want 2", dbg_state); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_drain_req: got %b want 0", imem_req); end
    @(posedge clk);
    #1 rst = 1'b0;
    ack_budget = 1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks = checks + 1;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dbg_state !== ST_FETCH) begin
      failures++; $display("FAIL rst_drain_restart: got req=%b addr=%h state=%0d want req=1 addr=0 state=0",
                           imem_req, imem_addr, dbg_state);
    end
    repeat (3) @(negedge clk);
    check_drained("rst_drain_deliver");
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    checks = checks + 1;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req2, imem_addr2);
    end
    @(negedge clk);
    checks = checks + 1;
    if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC || if_inst2 !== mem_word(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_top: got valid=%b pc=%h inst=%h want valid=1 pc=fffffffc inst=%h",
                           if_valid2, if_pc2, if_inst2, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk);
    checks = checks + 1;
    if (if_valid2 !== 1'b1 || if_pc2 !== 32'h0 || if_inst2 !== mem_word(32'h0)) begin
      failures++; $display("FAIL wrap_zero: got valid=%b pc=%h inst=%h want valid=1 pc=0 inst=%h",
                           if_valid2, if_pc2, if_inst2, mem_word(32'h0));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_br_stall();
    test_back_to_back();
    test_rst_drain();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port br_ctrl  input  1  taken branch/jump redirect from the execute stage.
REQ-005 SHALL have port br_pc  input  32  redirect target from the execute stage.
REQ-006 SHALL have port stall  input  1  hazard hold; the decode stage cannot accept an instruction.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  request address.
REQ-009 SHALL have port imem_ack  input  1  single-cycle response pulse; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port if_pc  output  32  PC of the delivered instruction.
REQ-012 SHALL have port if_inst  output  32  delivered instruction.
REQ-013 SHALL have port if_valid  output  1  if_pc and if_inst hold a live instruction.

Function
REQ-014 SHALL hold a fetch PC register pc_r and a state machine with states FETCH, HOLD and DRAIN.
REQ-015 SHALL drive imem_req=1 in FETCH and DRAIN, imem_req=0 in HOLD and in any cycle with rst=1, and SHALL drive imem_addr=pc_r.
REQ-016 SHALL keep imem_addr stable while imem_req=1 and no imem_ack has been received; an outstanding request is never withdrawn.
REQ-017 In FETCH with ack=1, stall=0 and br_ctrl=0, SHALL load if_inst<=imem_rdata, if_pc<=pc_r and if_valid<=1, set pc_r<=pc_r+4 and stay in FETCH, giving back-to-back fetch at one instruction per cycle.
REQ-018 In FETCH with ack=1, stall=1 and br_ctrl=0, SHALL capture rdata and pc_r into a skid buffer, keep the outputs unchanged and go to HOLD.
REQ-019 In HOLD with stall=0 and br_ctrl=0, SHALL move the skid buffer to the outputs with if_valid<=1, set pc_r<=pc_r+4 and return to FETCH.
REQ-020 With stall=1 and br_ctrl=0, SHALL leave if_pc, if_inst and if_valid unchanged in every state.
REQ-021 With ack=0, stall=0 and br_ctrl=0, SHALL set if_valid<=0 (bubble) and leave if_inst and if_pc unchanged.
REQ-022 br_ctrl SHALL take priority over stall and ack and SHALL set if_valid<=0 in the next cycle.
REQ-023 On br_ctrl in FETCH with ack=1, SHALL discard rdata, set pc_r<=br_pc and stay in FETCH.
REQ-024 On br_ctrl in FETCH with ack=0, SHALL latch redir_pc<=br_pc and go to DRAIN.
REQ-025 On br_ctrl in HOLD, SHALL discard the skid buffer, set pc_r<=br_pc and go to FETCH.
REQ-026 In DRAIN, br_ctrl SHALL overwrite redir_pc (latest wins); on ack, SHALL discard rdata, set pc_r<=redir_pc (or br_pc if br_ctrl is 1 that cycle) and go to FETCH; if_valid SHALL stay 0 throughout DRAIN.
REQ-027 SHALL clear br_pc[1:0] to 2'b00 when loading any redirect target.
REQ-028 pc_r+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-029 With rst=1 at a clock edge, SHALL set pc_r<=RESET_PC, state<=FETCH, if_valid<=0, if_inst<=32'h0000_0013 (NOP), if_pc<=32'h0, redir_pc<=0 and clear the skid buffer.
REQ-030 rst SHALL override every other input, including mid-DRAIN or mid-HOLD; any ack received while rst=1 SHALL be ignored.
REQ-031 The first request after rst is released SHALL be issued in the next cycle with imem_addr=RESET_PC.

Verification
REQ-032 Memory always acks, 4 cycles after reset with RESET_PC=0 -> if_pc=0,4,8,C on consecutive cycles, if_valid=1.
REQ-033 Stall asserted for 3 cycles while ack arrives for PC 0x10 -> outputs frozen, imem_req=0 in HOLD, and PC 0x10 is delivered exactly once after release, then 0x14.
REQ-034 br_ctrl=1 with br_pc=0x203 while a request is outstanding and ack is 2 cycles late -> late data dropped, next imem_addr=0x200, no if_valid between the redirect and the 0x200 delivery.
REQ-035 br_ctrl and stall both 1 in the same cycle -> if_valid=0 next cycle and fetch resumes at br_pc.
REQ-036 RESET_PC=0xFFFF_FFFC with ack always 1 -> deliveries at 0xFFFF_FFFC, then 0x0.
REQ-037 rst pulsed while in DRAIN -> the redirect is forgotten and the next imem_addr is RESET_PC.
